// File: rtl/fft_pkg.sv
// Shared FSM state type and bit-reversal helper for the FFT input buffer.
// Sizes stay per-instance parameters; nothing here fixes N or word width.
package fft_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    UNLOAD = 1'b1
  } fft_state_e;

  // Reverses the low w bits of v; bits at and above w come out as zero.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = v;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r = {r[30:0], s[0]};
        s = {1'b0, s[31:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// Frame storage: N entries of packed {real, imag}, one synchronous write
// port and two asynchronous read ports. Contents are never reset.
module fft_sample_ram
  import fft_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr0_i,
  output logic [DW-1:0] rdata0_o,
  input  logic [AW-1:0] raddr1_i,
  output logic [DW-1:0] rdata1_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Bit-reversing input buffer feeding stage-1 radix-2 butterflies.
// Define FFT_IN_SCALE_EN to prescale each sample by 1/N before storage.
module fft_bitrev_buffer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_r,
  input  logic [DATA_WIDTH-1:0] s_i,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] in1_r,
  output logic [DATA_WIDTH-1:0] in1_i,
  output logic [DATA_WIDTH-1:0] in2_r,
  output logic [DATA_WIDTH-1:0] in2_i,
  output logic [ADDR_WIDTH-1:0] tw_addr,
  output logic                  m_last
);

  localparam int N   = 1 << ADDR_WIDTH;
  localparam int DW  = DATA_WIDTH;
  localparam int AW  = ADDR_WIDTH;
  localparam int DW2 = 2 * DATA_WIDTH;

  localparam logic [AW-1:0] N_LAST = AW'(N - 1);
  localparam logic [AW-1:0] K_LAST = AW'(N / 2 - 1);

  fft_state_e state_q;
  logic [AW-1:0] n_q;
  logic [AW-1:0] k_q;
  logic s_ready_q;
  logic m_valid_q;

  logic [DW-1:0] s_r_d;
  logic [DW-1:0] s_i_d;
  logic [DW2-1:0] wdata_d;
  logic [DW2-1:0] rdata0;
  logic [DW2-1:0] rdata1;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr0;
  logic [AW-1:0] raddr1;
  logic we;
  logic pop;

  logic unused_q;
  assign unused_q = ^Q;

  always_comb begin
    s_r_d = s_r;
    s_i_d = s_i;
`ifdef FFT_IN_SCALE_EN
    s_r_d = DW'($signed(s_r) >>> AW);
    s_i_d = DW'($signed(s_i) >>> AW);
`endif
  end

  assign wdata_d = {s_r_d, s_i_d};
  assign we      = s_valid && s_ready_q;
  assign pop     = m_valid_q && m_ready;
  assign waddr   = AW'(bitrev(32'(n_q), AW));
  assign raddr0  = {k_q[AW-2:0], 1'b0};
  assign raddr1  = {k_q[AW-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      n_q       <= '0;
      k_q       <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (we) begin
            if (n_q == N_LAST) begin
              state_q   <= UNLOAD;
              n_q       <= '0;
              k_q       <= '0;
              s_ready_q <= 1'b0;
              m_valid_q <= 1'b1;
            end else begin
              n_q <= n_q + AW'(1);
            end
          end
        end
        UNLOAD: begin
          if (pop) begin
            if (k_q == K_LAST) begin
              state_q   <= LOAD;
              k_q       <= '0;
              s_ready_q <= 1'b1;
              m_valid_q <= 1'b0;
            end else begin
              k_q <= k_q + AW'(1);
            end
          end
        end
      endcase
    end
  end

  fft_sample_ram #(
    .DW(DW2),
    .AW(AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata_d),
    .raddr0_i(raddr0),
    .rdata0_o(rdata0),
    .raddr1_i(raddr1),
    .rdata1_o(rdata1)
  );

  // Operands are gated to zero whenever no pair is being offered.
  assign in1_r = m_valid_q ? rdata0[DW2-1:DW] : '0;
  assign in1_i = m_valid_q ? rdata0[DW-1:0]   : '0;
  assign in2_r = m_valid_q ? rdata1[DW2-1:DW] : '0;
  assign in2_i = m_valid_q ? rdata1[DW-1:0]   : '0;

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_valid_q && (k_q == K_LAST);
  assign tw_addr = '0;

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Randomized bench for fft_bitrev_buffer (N=8, 16-bit words) against a
// frame-level reference: pair k = (x[bitrev(2k)], x[bitrev(2k+1)]).
module tb_fft_bitrev_buffer;

  logic clk = 1'b0;
  logic rst_n;
  logic s_valid;
  logic s_ready;
  logic [15:0] s_r;
  logic [15:0] s_i;
  logic m_valid;
  logic m_ready;
  logic [15:0] in1_r;
  logic [15:0] in1_i;
  logic [15:0] in2_r;
  logic [15:0] in2_i;
  logic [2:0] tw_addr;
  logic m_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] xr [8];
  logic [15:0] xi [8];
  logic [15:0] gr1 [4];
  logic [15:0] gi1 [4];
  logic [15:0] gr2 [4];
  logic [15:0] gi2 [4];
  bit gl [4];
  int npairs;
  int first_wait;
  int load_start;
  bit saw_mv;
  bit saw_sr;

  fft_bitrev_buffer #(
    .DATA_WIDTH(16),
    .Q(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_r    (s_r),
    .s_i    (s_i),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .in1_r  (in1_r),
    .in1_i  (in1_i),
    .in2_r  (in2_r),
    .in2_i  (in2_i),
    .tw_addr(tw_addr),
    .m_last (m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int brev3(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 3; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  function automatic logic [15:0] sc(input logic [15:0] v);
`ifdef FFT_IN_SCALE_EN
    return 16'($signed(v) >>> 3);
`else
    return v;
`endif
  endfunction

  function automatic logic [63:0] exp_pair(input int k);
    int a;
    int b;
    a = brev3(2 * k);
    b = brev3(2 * k + 1);
    return {sc(xr[a]), sc(xi[a]), sc(xr[b]), sc(xi[b])};
  endfunction

  task automatic fill_ramp();
    for (int n = 0; n < 8; n++) begin
      xr[n] = 16'(n << 8);
      xi[n] = 16'(-(n << 8));
    end
  endtask

  task automatic fill_rand();
    for (int n = 0; n < 8; n++) begin
      xr[n] = 16'($urandom);
      xi[n] = 16'($urandom);
    end
  endtask

  // Offers xr/xi[0..cnt-1]; sparse uses the valid pattern 1,0,0,1,0,0,...
  task automatic load_frame(input bit sparse, input int cnt);
    int i;
    int t;
    i = 0;
    t = 0;
    saw_mv = 0;
    while (i < cnt && t < 100) begin
      @(negedge clk);
      if (t == 0) load_start = cyc;
      if (m_valid) saw_mv = 1;
      if (sparse && (t % 3 != 0)) begin
        s_valid = 1'b0;
        s_r = 16'hDEAD;
        s_i = 16'hBEEF;
      end else begin
        s_valid = 1'b1;
        s_r = xr[i];
        s_i = xi[i];
      end
      if (s_valid && s_ready) i++;
      t++;
    end
  endtask

  task automatic collect(input int want, input bit junk, input bit rnd);
    int t;
    t = 0;
    npairs = 0;
    first_wait = -1;
    saw_sr = 0;
    while (npairs < want && t < 80) begin
      @(negedge clk);
      if (junk) begin
        s_valid = 1'b1;
        s_r = 16'($urandom);
        s_i = 16'($urandom);
      end else begin
        s_valid = 1'b0;
      end
      m_ready = rnd ? 1'($urandom % 2) : 1'b1;
      if (s_ready) saw_sr = 1;
      if (m_valid && first_wait < 0) first_wait = t;
      if (m_valid && m_ready) begin
        gr1[npairs] = in1_r;
        gi1[npairs] = in1_i;
        gr2[npairs] = in2_r;
        gi2[npairs] = in2_i;
        gl[npairs] = m_last;
        npairs++;
      end
      t++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_r = '0;
    s_i = '0;
    #12;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got s_ready=%b m_valid=%b want 1 0", s_ready, m_valid);
    end
    checks++;
    if (m_last !== 1'b0 || tw_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_last_tw got m_last=%b tw=%0d want 0 0", m_last, tw_addr);
    end
    checks++;
    if ({in1_r, in1_i, in2_r, in2_i} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {in1_r, in1_i, in2_r, in2_i});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    fill_ramp();
    load_frame(0, 8);
    collect(4, 0, 0);
    checks++;
    if (saw_mv !== 1'b0) begin
      errors++;
      $display("FAIL basic_mv_in_load got 1 want 0");
    end
    checks++;
    if (first_wait !== 0 || npairs !== 4) begin
      errors++;
      $display("FAIL basic_latency got wait=%0d pairs=%0d want 0 4", first_wait, npairs);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({gr1[k], gi1[k], gr2[k], gi2[k]} !== exp_pair(k) || gl[k] !== (k == 3)) begin
        errors++;
        $display("FAIL basic_pair%0d got %h last=%b want %h last=%b", k,
                 {gr1[k], gi1[k], gr2[k], gi2[k]}, gl[k], exp_pair(k), k == 3);
      end
    end
    checks++;
    if (saw_sr !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_in_unload got 1 want 0");
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    fill_ramp();
    load_frame(0, 8);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in1_r !== sc(16'h0200) || in2_r !== sc(16'h0600)) begin
      errors++;
      $display("FAIL bp_pair1 got %h %h want %h %h", in1_r, in2_r,
               sc(16'h0200), sc(16'h0600));
    end
    held = {in1_r, in1_i, in2_r, in2_i};
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({in1_r, in1_i, in2_r, in2_i} !== held || m_valid !== 1'b1 || m_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got %h v=%b l=%b want %h 1 0", c,
                 {in1_r, in1_i, in2_r, in2_i}, m_valid, m_last, held);
      end
    end
    collect(3, 0, 0);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({gr1[j], gi1[j], gr2[j], gi2[j]} !== exp_pair(j + 1) || gl[j] !== (j == 2)) begin
        errors++;
        $display("FAIL bp_pair%0d got %h want %h", j + 1,
                 {gr1[j], gi1[j], gr2[j], gi2[j]}, exp_pair(j + 1));
      end
    end
  endtask

  task automatic test_sparse_valid();
    fill_ramp();
    load_frame(1, 8);
    collect(4, 1, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({gr1[k], gi1[k], gr2[k], gi2[k]} !== exp_pair(k) || gl[k] !== (k == 3)) begin
        errors++;
        $display("FAIL sparse_pair%0d got %h want %h", k,
                 {gr1[k], gi1[k], gr2[k], gi2[k]}, exp_pair(k));
      end
    end
    checks++;
    if (saw_sr !== 1'b0 || first_wait !== 0) begin
      errors++;
      $display("FAIL sparse_unload got ready_seen=%b wait=%0d want 0 0", saw_sr, first_wait);
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || in1_r !== 16'd0) begin
      errors++;
      $display("FAIL sparse_after got rdy=%b v=%b l=%b in1_r=%h want 1 0 0 0",
               s_ready, m_valid, m_last, in1_r);
    end
  endtask

  task automatic test_mid_reset();
    fill_rand();
    load_frame(0, 5);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got rdy=%b v=%b want 1 0", s_ready, m_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand();
    load_frame(0, 8);
    collect(4, 0, 0);
    checks++;
    if (saw_mv !== 1'b0 || first_wait !== 0) begin
      errors++;
      $display("FAIL midrst_valid got early=%b wait=%0d want 0 0", saw_mv, first_wait);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({gr1[k], gi1[k], gr2[k], gi2[k]} !== exp_pair(k)) begin
        errors++;
        $display("FAIL midrst_pair%0d got %h want %h", k,
                 {gr1[k], gi1[k], gr2[k], gi2[k]}, exp_pair(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int c1;
    for (int f = 0; f < 2; f++) begin
      fill_rand();
      load_frame(0, 8);
      if (f == 0) c0 = load_start;
      else c1 = load_start;
      collect(4, 0, 0);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({gr1[k], gi1[k], gr2[k], gi2[k]} !== exp_pair(k)) begin
          errors++;
          $display("FAIL b2b_f%0d_pair%0d got %h want %h", f, k,
                   {gr1[k], gi1[k], gr2[k], gi2[k]}, exp_pair(k));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (c1 - c0 !== 12 || cyc - c0 !== 24 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_cycles got frame=%0d total=%0d rdy=%b want 12 24 1",
               c1 - c0, cyc - c0, s_ready);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      fill_rand();
      load_frame(f[0], 8);
      collect(4, 1, 1);
      checks++;
      if (npairs !== 4) begin
        errors++;
        $display("FAIL rnd_f%0d_count got %0d want 4", f, npairs);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({gr1[k], gi1[k], gr2[k], gi2[k]} !== exp_pair(k) || gl[k] !== (k == 3)) begin
          errors++;
          $display("FAIL rnd_f%0d_pair%0d got %h want %h", f, k,
                   {gr1[k], gi1[k], gr2[k], gi2[k]}, exp_pair(k));
        end
      end
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

`ifdef FFT_IN_SCALE_EN
  task automatic test_scale();
    for (int n = 0; n < 8; n++) begin
      xr[n] = '0;
      xi[n] = '0;
    end
    xr[0] = 16'h0800;
    xr[1] = 16'hF800;
    load_frame(0, 8);
    collect(4, 0, 0);
    checks++;
    if (gr1[0] !== 16'h0100 || gr1[2] !== 16'hFF00) begin
      errors++;
      $display("FAIL scale got %h %h want 0100 ff00", gr1[0], gr1[2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sparse_valid();
    test_mid_reset();
    test_back_to_back();
    test_random();
`ifdef FFT_IN_SCALE_EN
    test_scale();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_buffer.md
FFT_BITREV_BUFFER -- requirements
Module: fft_bitrev_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the two's-complement width of each real/imag word.
REQ-002 SHALL have parameter Q, default 8, meaning the fractional bits of the fixed-point format; it is passed through and unused internally.
REQ-003 SHALL have parameter ADDR_WIDTH, default 3, meaning log2 of the FFT size N.
REQ-004 Ports (name, direction, width, meaning), clock and reset first:
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  s_valid  in  1  input sample valid.
  s_ready  out  1  buffer accepts a sample.
  s_r, s_i  in  DATA_WIDTH each  input sample, natural time order.
  m_valid  out  1  butterfly pair valid.
  m_ready  in  1  downstream butterfly consumes the pair.
  in1_r, in1_i, in2_r, in2_i  out  DATA_WIDTH each  stage-1 butterfly operands.
  tw_addr  out  ADDR_WIDTH  twiddle ROM address; constant 0 for stage 1.
  m_last  out  1  final pair of the frame.

Function
REQ-005 SHALL implement a two-state FSM, LOAD and UNLOAD, with reset state LOAD.
REQ-006 In LOAD: s_ready=1; m_valid=0; each s_valid&&s_ready beat SHALL write sample index n (0..N-1) to storage address bitrev(n), then n increments.
REQ-007 The beat with n=N-1 SHALL, on the same edge, move the FSM to UNLOAD and clear n and pair counter k.
REQ-008 In UNLOAD: s_ready=0; m_valid=1; in1=mem[2k], in2=mem[2k+1], driven combinationally from storage with zero added latency.
REQ-009 m_valid&&m_ready SHALL increment k; when m_valid&&m_ready occurs with k=N/2-1, the FSM SHALL return to LOAD with k=0.
REQ-010 m_last SHALL equal m_valid && (k==N/2-1).
REQ-011 While m_valid=1 and m_ready=0, all m_* outputs SHALL hold stable.
REQ-012 When m_valid=0, in1_r/in1_i/in2_r/in2_i and m_last SHALL be 0.
REQ-013 s_valid during UNLOAD SHALL be ignored, with no write and no counter change.
REQ-014 The first m_valid SHALL assert the cycle after the N-th accepted sample; the first s_ready SHALL assert the cycle after the final pair handshake.
REQ-015 bitrev SHALL reverse the ADDR_WIDTH index bits.
REQ-016 Data SHALL be stored without width change unless FFT_IN_SCALE_EN is defined.

Reset
REQ-017 Reset SHALL be asynchronous on rst_n low and SHALL set FSM=LOAD, n=0, k=0, s_ready=1, m_valid=0, m_last=0, data outputs=0 and tw_addr=0.
REQ-018 Storage SHALL not be reset.
REQ-019 A reset mid-LOAD or mid-UNLOAD SHALL abort the frame; the next accepted sample is n=0.

Configuration
REQ-020 With macro FFT_IN_SCALE_EN defined, each sample SHALL be arithmetic-right-shifted by ADDR_WIDTH bits before storage (1/N prescale, sign-preserving, truncating).
REQ-021 Without FFT_IN_SCALE_EN, samples SHALL be stored unmodified.

Structure
REQ-022 Shared package fft_pkg SHALL hold the FSM state typedef and the bitrev function; per-instance sizes remain parameters, not package constants.
REQ-023 Storage SHALL be a sub-module fft_sample_ram: N x 2*DATA_WIDTH, one synchronous write port, two asynchronous read ports.

Verification (N=8, DATA_WIDTH=16)
REQ-024 Load s_r=n<<8 (n=0..7), s_i=-(n<<8), back-to-back, m_ready=1 -> pairs (0,4),(2,6),(1,5),(3,7) in units of 0x0100, imag negated; m_last only on the 4th pair.
REQ-025 Hold m_ready=0 for 3 cycles on pair k=1 -> in1_r=0x0200 and in2_r=0x0600 stable for all 3 cycles; k advances only on the handshake.
REQ-026 Toggle s_valid 1,0,0,1,... with s_valid asserted during UNLOAD -> identical output order to REQ-024; s_ready=0 throughout UNLOAD; no corruption.
REQ-027 Assert rst_n=0 after 5 loaded samples, release, then load a full frame -> output comes only from the new frame; m_valid=0 until 8 post-reset samples are accepted.
REQ-028 With FFT_IN_SCALE_EN defined, samples 0x0800 and 0xF800 -> stored and output as 0x0100 and 0xFF00.
REQ-029 Two back-to-back frames with m_ready=1 -> exactly 8 load cycles plus 4 unload cycles per frame, with no lost beats.
